// File: rtl/child_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : child_rr_scheduler_if
// Description : Request/grant bundle between the five child instances and the
//               shared-resource round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface child_rr_scheduler_if #(
  parameter int NUM_REQ = 5
);

  // Per-child request level and completion pulse
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;

  // Grant side, all register-driven by the scheduler
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [2:0]         gnt_id;
  logic               timeout_pulse;
  logic               busy;

  // Children side: raise requests, consume grants
  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout_pulse,
    input  busy
  );

  // Scheduler side: observe requests, drive grants
  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout_pulse,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/child_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : child_rr_scheduler
// Description : Round-robin scheduler sharing one resource among five
//               children. One grant at a time, held until done, request
//               withdrawal or hold timeout, followed by one dead cycle in
//               which priority rotates past the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module child_rr_scheduler #(
  parameter int NUM_REQ = 5,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  child_rr_scheduler_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0]         c_LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = NUM_REQ'(1);
  // The counter holds 0 in the first grant cycle; the grant is revoked on the
  // edge where it would reach TIMEOUT-1, so the grant lasts TIMEOUT-1 cycles.
  localparam logic [CW-1:0]      c_CNT_LAST = CW'(TIMEOUT - 2);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_gnt_valid;
  logic [2:0]         r_gnt_id;
  logic               r_timeout_pulse;
  logic               r_busy;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [2:0]         w_ptr_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic               w_gnt_valid_nxt;
  logic [2:0]         w_gnt_id_nxt;
  logic               w_timeout_pulse_nxt;
  logic               w_busy_nxt;

  logic [3:0]         w_pick;
  logic               w_pick_found;
  logic [2:0]         w_pick_id;
  logic               w_any_req;
  logic               w_finish;
  logic               w_expire;
  logic [2:0]         w_ptr_after;

  // --------------------------------------------------------------------------
  // Round-robin pick: scan upward from start with wrap, first set request
  // wins. Returns {found, index}.
  // --------------------------------------------------------------------------
  function automatic logic [3:0] rr_pick(
    input logic [NUM_REQ-1:0] req_v,
    input logic [2:0]         start
  );
    logic [3:0] result;
    logic [2:0] idx;
    int         pos;
    result = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(start) + i) % NUM_REQ;
      idx = 3'(pos);
      if (!result[3] && req_v[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  // Arbitration result and grant-exit conditions for the current cycle
  always_comb begin
    w_pick       = rr_pick(bus.req, r_ptr);
    w_pick_found = w_pick[3];
    w_pick_id    = w_pick[2:0];
    w_any_req    = |bus.req;
    // Only the granted child's done/request bits matter
    w_finish     = bus.done[r_gnt_id] | ~bus.req[r_gnt_id];
    w_expire     = (r_cnt == c_CNT_LAST);
    w_ptr_after  = (r_gnt_id == c_LAST_IDX) ? 3'd0 : (r_gnt_id + 3'd1);
  end

  // Next-state and next-output logic of the IDLE/GRANT/RELEASE machine
  always_comb begin
    w_state_nxt         = r_state;
    w_ptr_nxt           = r_ptr;
    w_cnt_nxt           = r_cnt;
    w_gnt_nxt           = r_gnt;
    w_gnt_id_nxt        = r_gnt_id;
    w_timeout_pulse_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req && w_pick_found) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = c_ONE_HOT0 << w_pick_id;
          w_gnt_id_nxt = w_pick_id;
          w_cnt_nxt    = '0;
        end
      end

      S_GRANT: begin
        if (w_finish || w_expire) begin
          // Done or withdrawal outranks the timeout: no pulse if they coincide
          w_state_nxt         = S_RELEASE;
          w_gnt_nxt           = '0;
          w_ptr_nxt           = w_ptr_after;
          w_cnt_nxt           = '0;
          w_timeout_pulse_nxt = ~w_finish;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_RELEASE: begin
        // r_ptr already points past the previous winner here
        if (w_any_req && w_pick_found) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = c_ONE_HOT0 << w_pick_id;
          w_gnt_id_nxt = w_pick_id;
          w_cnt_nxt    = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    w_gnt_valid_nxt = |w_gnt_nxt;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ptr           <= 3'd0;
      r_cnt           <= '0;
      r_gnt           <= '0;
      r_gnt_valid     <= 1'b0;
      r_gnt_id        <= 3'd0;
      r_timeout_pulse <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_ptr           <= w_ptr_nxt;
      r_cnt           <= w_cnt_nxt;
      r_gnt           <= w_gnt_nxt;
      r_gnt_valid     <= w_gnt_valid_nxt;
      r_gnt_id        <= w_gnt_id_nxt;
      r_timeout_pulse <= w_timeout_pulse_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign bus.gnt           = r_gnt;
  assign bus.gnt_valid     = r_gnt_valid;
  assign bus.gnt_id        = r_gnt_id;
  assign bus.timeout_pulse = r_timeout_pulse;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire
